// File: rtl/freelist_nway_if.sv
// Rename-side bundle for the N-way physical-register free list.
// "master" is the rename/retire logic; "slave" is the free list.
interface freelist_nway_if #(
    parameter int WAYS = 2,
    parameter int PW   = 6
);
    logic                 stall;
    logic                 rollback;
    logic [WAYS-1:0]      alloc_req;
    logic [WAYS*PW-1:0]   alloc_tag;
    logic                 alloc_ok;
    logic [WAYS-1:0]      retire_alloc;
    logic [WAYS-1:0]      free_en;
    logic [WAYS*PW-1:0]   free_tag;
    logic [PW:0]          free_count;
    logic                 empty;
    logic                 overflow_err;

    modport master (
        output stall, rollback, alloc_req, retire_alloc, free_en, free_tag,
        input  alloc_tag, alloc_ok, free_count, empty, overflow_err
    );

    modport slave (
        input  stall, rollback, alloc_req, retire_alloc, free_en, free_tag,
        output alloc_tag, alloc_ok, free_count, empty, overflow_err
    );
endinterface

// File: rtl/freelist_nway.sv
// N-way circular free list of physical register tags with a retirement head
// for single-cycle reclaim of speculative allocations on rollback.
module freelist_nway #(
    parameter int WAYS     = 2,
    parameter int NUM_PREG = 64,
    parameter int NUM_AREG = 32,
    localparam int PW      = $clog2(NUM_PREG),
    localparam int DEPTH   = NUM_PREG - NUM_AREG,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic clock,
    input  logic reset,
    freelist_nway_if.slave fl
);
    // Pointers carry one wrap bit above the index; DEPTH is a power of two.
    localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

    logic [PW-1:0] entry_reg [DEPTH];
    logic [AW:0]   spec_head_reg, retire_head_reg, tail_reg, count_reg;
    logic          overflow_reg;

    logic [AW:0]   spec_head_next, retire_head_next, tail_next, count_next;
    logic          overflow_next;

    logic [AW:0]   req_pre  [WAYS+1];
    logic [AW:0]   free_pre [WAYS+1];
    logic [AW:0]   ret_pre  [WAYS+1];
    logic [WAYS-1:0] free_vld;
    logic [WAYS-1:0] free_acc;
    logic [AW-1:0] rd_idx [WAYS];
    logic [AW-1:0] wr_idx [WAYS];

    logic [AW:0]   n_req, n_free, n_ret, n_acc, space;
    logic          alloc_ok;

    assign req_pre[0]  = '0;
    assign free_pre[0] = '0;
    assign ret_pre[0]  = '0;
    assign space       = DEPTH_P - count_reg;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_lane
            assign req_pre[gi+1] = req_pre[gi] + (AW+1)'(fl.alloc_req[gi]);
            assign ret_pre[gi+1] = ret_pre[gi] + (AW+1)'(fl.retire_alloc[gi]);

            // Tag 0 is the hardwired zero register and must never enter the list.
            assign free_vld[gi]   = fl.free_en[gi] && (fl.free_tag[gi*PW +: PW] != '0);
            assign free_pre[gi+1] = free_pre[gi] + (AW+1)'(free_vld[gi]);
            assign free_acc[gi]   = free_vld[gi] && (free_pre[gi] < space);

            assign rd_idx[gi] = spec_head_reg[AW-1:0] + req_pre[gi][AW-1:0];
            assign wr_idx[gi] = tail_reg[AW-1:0] + free_pre[gi][AW-1:0];

            assign fl.alloc_tag[gi*PW +: PW] = fl.alloc_req[gi] ? entry_reg[rd_idx[gi]] : '0;
        end
    endgenerate

    assign n_req  = req_pre[WAYS];
    assign n_free = free_pre[WAYS];
    assign n_ret  = ret_pre[WAYS];
    assign n_acc  = (n_free > space) ? space : n_free;

    assign alloc_ok = !reset && !fl.stall && !fl.rollback && (n_req <= count_reg);

    always_comb begin
        retire_head_next = retire_head_reg + n_ret;
        spec_head_next   = spec_head_reg;
        if (fl.rollback) begin
            spec_head_next = retire_head_reg + n_ret;
        end else if (alloc_ok) begin
            spec_head_next = spec_head_reg + n_req;
        end
        tail_next     = tail_reg + n_acc;
        count_next    = tail_next - spec_head_next;
        overflow_next = overflow_reg || (n_free > space);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            spec_head_reg   <= '0;
            retire_head_reg <= '0;
            // Index 0 with the wrap bit set: the list starts completely full.
            tail_reg        <= DEPTH_P;
            count_reg       <= DEPTH_P;
            overflow_reg    <= 1'b0;
        end else begin
            spec_head_reg   <= spec_head_next;
            retire_head_reg <= retire_head_next;
            tail_reg        <= tail_next;
            count_reg       <= count_next;
            overflow_reg    <= overflow_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                entry_reg[e] <= PW'(NUM_AREG + e);
            end
        end else begin
            for (int k = 0; k < WAYS; k++) begin
                if (free_acc[k]) begin
                    entry_reg[wr_idx[k]] <= fl.free_tag[k*PW +: PW];
                end
            end
        end
    end

    assign fl.alloc_ok     = alloc_ok;
    assign fl.free_count   = (PW+1)'(count_reg);
    assign fl.empty        = (count_reg == '0);
    assign fl.overflow_err = overflow_reg;
endmodule

// File: tb/tb_freelist_nway.sv
// Directed checks of the 2-way free list: reset, exhaust, sparse lanes,
// free/recycle, stall, rollback and overflow.
module tb_freelist_nway;
    localparam int WAYS     = 2;
    localparam int NUM_PREG = 64;
    localparam int NUM_AREG = 32;
    localparam int PW       = 6;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    freelist_nway_if #(.WAYS(WAYS), .PW(PW)) fl_if ();

    freelist_nway #(
        .WAYS(WAYS),
        .NUM_PREG(NUM_PREG),
        .NUM_AREG(NUM_AREG)
    ) dut (
        .clock(clock),
        .reset(reset),
        .fl(fl_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        fl_if.stall        = 1'b0;
        fl_if.rollback     = 1'b0;
        fl_if.alloc_req    = '0;
        fl_if.retire_alloc = '0;
        fl_if.free_en      = '0;
        fl_if.free_tag     = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    function automatic int tag0();
        logic [WAYS*PW-1:0] t;
        t = fl_if.alloc_tag;
        return int'(t[PW-1:0]);
    endfunction

    function automatic int tag1();
        logic [WAYS*PW-1:0] t;
        t = fl_if.alloc_tag;
        return int'(t[2*PW-1:PW]);
    endfunction

    initial begin
        idle();
        #2;
        // Reset: outputs while reset held, with a request pending.
        reset = 1'b1;
        fl_if.alloc_req = 2'b11;
        tick();
        chk("rst_free_count", int'(fl_if.free_count), 32);
        chk("rst_empty", int'(fl_if.empty), 0);
        chk("rst_overflow", int'(fl_if.overflow_err), 0);
        chk("rst_alloc_ok", int'(fl_if.alloc_ok), 0);
        reset = 1'b0;

        // Exhaust: 16 double allocations walk tags 32..63.
        for (int c = 0; c < 16; c++) begin
            fl_if.alloc_req = 2'b11;
            #1;
            chk($sformatf("exh_tag0_c%0d", c), tag0(), 32 + 2*c);
            chk($sformatf("exh_tag1_c%0d", c), tag1(), 33 + 2*c);
            chk($sformatf("exh_ok_c%0d", c), int'(fl_if.alloc_ok), 1);
            tick();
            if (c == 0) chk("first_free_count", int'(fl_if.free_count), 30);
        end
        idle();
        chk("exh_empty", int'(fl_if.empty), 1);
        chk("exh_free_count", int'(fl_if.free_count), 0);
        fl_if.alloc_req = 2'b01;
        #1;
        chk("exh_deny_ok", int'(fl_if.alloc_ok), 0);
        tick();
        chk("exh_deny_count", int'(fl_if.free_count), 0);

        // Free 5 and 0: only 5 enters; not allocatable in the same cycle.
        fl_if.alloc_req = 2'b01;
        fl_if.free_en   = 2'b11;
        fl_if.free_tag  = {6'd0, 6'd5};
        #1;
        chk("free_same_cycle_ok", int'(fl_if.alloc_ok), 0);
        tick();
        idle();
        chk("free_count_after", int'(fl_if.free_count), 1);
        chk("free_empty_after", int'(fl_if.empty), 0);
        #1;
        chk("zero_req_ok", int'(fl_if.alloc_ok), 1);
        fl_if.alloc_req = 2'b01;
        #1;
        chk("recycle_tag0", tag0(), 5);
        chk("recycle_ok", int'(fl_if.alloc_ok), 1);
        tick();
        idle();
        chk("recycle_count", int'(fl_if.free_count), 0);

        // Sparse lanes: only lane 1 requests.
        do_reset();
        fl_if.alloc_req = 2'b10;
        #1;
        chk("sparse_tag1", tag1(), 32);
        chk("sparse_tag0", tag0(), 0);
        chk("sparse_ok", int'(fl_if.alloc_ok), 1);
        tick();
        chk("sparse_count", int'(fl_if.free_count), 31);
        fl_if.alloc_req = 2'b01;
        #1;
        chk("sparse_next_tag0", tag0(), 33);
        tick();
        idle();

        // Stall blocks allocation.
        do_reset();
        fl_if.stall     = 1'b1;
        fl_if.alloc_req = 2'b11;
        #1;
        chk("stall_ok", int'(fl_if.alloc_ok), 0);
        tick();
        idle();
        chk("stall_count", int'(fl_if.free_count), 32);

        // Rollback: 6 allocated, 2 retired, then rollback retiring 1 more.
        for (int c = 0; c < 3; c++) begin
            fl_if.alloc_req = 2'b11;
            tick();
        end
        idle();
        chk("rb_pre_count", int'(fl_if.free_count), 26);
        fl_if.retire_alloc = 2'b11;
        tick();
        idle();
        chk("rb_retire_count", int'(fl_if.free_count), 26);
        fl_if.rollback     = 1'b1;
        fl_if.stall        = 1'b1;
        fl_if.retire_alloc = 2'b01;
        fl_if.alloc_req    = 2'b11;
        #1;
        chk("rb_alloc_ok", int'(fl_if.alloc_ok), 0);
        tick();
        idle();
        chk("rb_count", int'(fl_if.free_count), 29);
        fl_if.alloc_req = 2'b01;
        #1;
        chk("rb_next_tag0", tag0(), 35);
        tick();
        idle();

        // Overflow: freeing into a full list.
        do_reset();
        chk("ovf_pre", int'(fl_if.overflow_err), 0);
        fl_if.free_en  = 2'b01;
        fl_if.free_tag = {6'd0, 6'd7};
        tick();
        idle();
        chk("ovf_err", int'(fl_if.overflow_err), 1);
        chk("ovf_count", int'(fl_if.free_count), 32);
        fl_if.alloc_req = 2'b01;
        #1;
        chk("ovf_entry_intact", tag0(), 32);
        tick();
        idle();
        chk("ovf_sticky", int'(fl_if.overflow_err), 1);
        do_reset();
        chk("ovf_cleared", int'(fl_if.overflow_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
